set_assoc_cache: RTL
====================

Name: set_assoc_cache

Overview:
- Parametrised N-way set-associative, write-back, write-allocate cache with true-LRU replacement.
- Sits between the CPU load/store port and a slower backing-memory port; successor to the single-way, no-backing-store cache.
- Adds a valid/ready request handshake, a backing-memory request/acknowledge interface, dirty-line writeback, and hit/miss statistics counters.

Parameters:
DATA_WIDTH  32  width of a cache word; one word per line
ADDR_WIDTH  8  word address width
NUM_SETS  8  number of sets; power of 2, >=2; INDEX_W = log2(NUM_SETS)
NUM_WAYS  2  associativity; power of 2, >=1; tag width TAG_W = ADDR_WIDTH-INDEX_W
CNT_WIDTH  16  width of statistics counters

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  CPU request valid
req_ready  out  1  cache can accept a request
req_write  in  1  1=store, 0=load
req_addr  in  ADDR_WIDTH  word address; index=addr[INDEX_W-1:0], tag=addr[ADDR_WIDTH-1:INDEX_W]
req_wdata  in  DATA_WIDTH  store data
resp_valid  out  1  one-cycle response strobe
resp_hit  out  1  1 if request hit; valid with resp_valid
resp_rdata  out  DATA_WIDTH  load data; valid with resp_valid (loads only, else 0)
mem_req  out  1  backing-memory request, held until mem_ack
mem_we  out  1  1=writeback, 0=refill read
mem_addr  out  ADDR_WIDTH  backing-memory word address
mem_wdata  out  DATA_WIDTH  writeback data
mem_rdata  in  DATA_WIDTH  refill data, valid with mem_ack
mem_ack  in  1  one-cycle completion from backing memory
hit_count  out  CNT_WIDTH  saturating count of hits
miss_count  out  CNT_WIDTH  saturating count of misses

Behaviour:
- Reset (sync, rst high at edge):
  - All valid/dirty bits cleared; tag/data arrays not cleared.
  - LRU age of way w in every set = w.
  - FSM to IDLE.
  - Outputs: req_ready=1; resp_valid, resp_hit, resp_rdata, mem_req, mem_we, mem_addr, mem_wdata = 0; counters = 0.
- Reset mid-operation:
  - Any outstanding memory transaction is abandoned; mem_req=0 the cycle after the reset edge.
  - A late mem_ack arriving in IDLE is ignored.
- FSM states: IDLE, RESP, WRITEBACK, REFILL.
- IDLE:
  - req_ready=1. Request accepted on an edge with req_valid=1; address, data and write flag are latched.
  - Tag compare over all ways of the indexed set. A hit requires a valid entry with a matching tag.
  - Hit load → RESP.
  - Hit store → write the word, set dirty → RESP.
  - Miss: victim = lowest-index invalid way; if none, the way with age NUM_WAYS-1.
    - Victim valid and dirty → WRITEBACK.
    - Else if load → REFILL.
    - Else (store) → install tag/data, valid=1, dirty=1 → RESP. No memory traffic.
- WRITEBACK:
  - Drive mem_req=1, mem_we=1, mem_addr={victim_tag,index}, mem_wdata=victim data; hold until mem_ack.
  - On mem_ack: clear victim dirty, then store miss → install (valid, dirty) → RESP; load miss → REFILL.
- REFILL:
  - Drive mem_req=1, mem_we=0, mem_addr=latched addr; hold until mem_ack.
  - On mem_ack: install mem_rdata, valid=1, dirty=0, capture resp_rdata → RESP.
- RESP:
  - resp_valid=1 for exactly one cycle; req_ready=0; then → IDLE.
  - resp_hit=1 only if the original lookup hit.
- Latency: hit → resp_valid on cycle 2 after acceptance (accept edge, RESP register). Miss latency adds memory wait cycles.
- req_ready=0 in every state except IDLE; req_valid is ignored when req_ready=0.
- LRU update on every access (hit, or install on miss), in the accessed way w with old age a:
  - Ways in the set with age < a increment; way w gets age 0.
  - Ages in a set remain a permutation of 0..NUM_WAYS-1.
- NUM_WAYS=1: direct-mapped; the victim is always way 0.
- Counters:
  - hit_count increments on each hit lookup; miss_count on each miss lookup, at decision time in IDLE.
  - Both saturate at 2^CNT_WIDTH-1; no wrap.
- mem_req deasserts the cycle after mem_ack. mem_ack while mem_req=0 is ignored.

Test Plan (NUM_SETS=8, NUM_WAYS=2; backing memory acks 3 cycles after mem_req; addrs 0x08/0x10/0x18 share index 0):
1. After reset, store 0x08=0x12345678 → resp_hit=0, no mem_req. Load 0x08 → resp_hit=1, resp_rdata=0x12345678, resp_valid 2 cycles after accept; hit_count=1, miss_count=1.
2. Load 0x04 with memory returning 0xA5A5A5A5 → mem_req, mem_we=0, mem_addr=0x04, resp_hit=0, resp_rdata=0xA5A5A5A5. Reload 0x04 → hit, no mem_req.
3. Store 0x08=0xDEADBEEF, store 0x10=0xCAFEF00D, load 0x08, load 0x18 → writeback mem_we=1, mem_addr=0x10, mem_wdata=0xCAFEF00D, then refill 0x18. Load 0x08 → hit 0xDEADBEEF; load 0x10 → miss.
4. Load miss to 0x20; assert rst for one edge while in REFILL with mem_req=1 → next cycle mem_req=0, req_ready=1, counters=0. Late mem_ack ignored. Load 0x08 → miss.
5. Hold req_valid=1 during RESP/REFILL with a different addr → not accepted until req_ready=1; exactly one resp_valid per accepted request.
6. CNT_WIDTH=2: issue 5 hits → hit_count saturates at 3.

Source files
------------

// File: rtl/set_assoc_cache.sv
// N-way set-associative, write-back, write-allocate cache with true-LRU replacement,
// a valid/ready CPU port, a req/ack backing-memory port and saturating hit/miss counters.
module set_assoc_cache #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int NUM_SETS   = 8,
   parameter int NUM_WAYS   = 2,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   output logic                  resp_hit,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ack,
   output logic [CNT_WIDTH-1:0]  hit_count,
   output logic [CNT_WIDTH-1:0]  miss_count
);
   localparam int INDEX_W = $clog2(NUM_SETS);
   localparam int TAG_W   = ADDR_WIDTH - INDEX_W;
   localparam int WAY_W   = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RESP, S_WRITEBACK, S_REFILL} state_t;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   state_t                r_state, w_next;
   logic                  r_valid [NUM_SETS][NUM_WAYS];
   logic                  r_dirty [NUM_SETS][NUM_WAYS];
   logic [TAG_W-1:0]      r_tag   [NUM_SETS][NUM_WAYS];
   logic [DATA_WIDTH-1:0] r_data  [NUM_SETS][NUM_WAYS];
   logic [WAY_W-1:0]      r_age   [NUM_SETS][NUM_WAYS];

   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata, r_rdata;
   logic                  r_write, r_hit;
   logic [WAY_W-1:0]      r_way;
   logic [CNT_WIDTH-1:0]  r_hit_cnt, r_miss_cnt;

   logic [INDEX_W-1:0]    w_idx, w_ridx;
   logic [TAG_W-1:0]      w_tag, w_rtag;
   logic                  w_hit, w_inv_found, w_vict_dirty;
   logic [WAY_W-1:0]      w_hit_way, w_inv_way, w_lru_way, w_vict, w_acc_way;

   logic                  w_wr_en, w_wr_dirty, w_clr_dirty, w_touch, w_accept;
   logic                  w_cnt_hit, w_cnt_miss;
   logic [INDEX_W-1:0]    w_wr_idx;
   logic [WAY_W-1:0]      w_wr_way;
   logic [TAG_W-1:0]      w_wr_tag;
   logic [DATA_WIDTH-1:0] w_wr_data;

   assign w_idx  = req_addr[INDEX_W-1:0];
   assign w_tag  = req_addr[ADDR_WIDTH-1:INDEX_W];
   assign w_ridx = r_addr[INDEX_W-1:0];
   assign w_rtag = r_addr[ADDR_WIDTH-1:INDEX_W];

   // Lookup: descending scan so the lowest-index match/invalid way wins.
   always_comb begin
      w_hit       = 1'b0;
      w_hit_way   = '0;
      w_inv_found = 1'b0;
      w_inv_way   = '0;
      w_lru_way   = '0;
      for (int k = NUM_WAYS - 1; k >= 0; k--) begin
         if (r_valid[w_idx][k] && (r_tag[w_idx][k] == w_tag)) begin
            w_hit     = 1'b1;
            w_hit_way = WAY_W'(k);
         end
         if (!r_valid[w_idx][k]) begin
            w_inv_found = 1'b1;
            w_inv_way   = WAY_W'(k);
         end
         if (r_age[w_idx][k] == WAY_W'(NUM_WAYS - 1))
            w_lru_way = WAY_W'(k);
      end
      w_vict       = w_inv_found ? w_inv_way : w_lru_way;
      w_vict_dirty = r_valid[w_idx][w_vict] && r_dirty[w_idx][w_vict];
      w_acc_way    = w_hit ? w_hit_way : w_vict;
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      req_ready   = 1'b0;
      resp_valid  = 1'b0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      w_accept    = 1'b0;
      w_wr_en     = 1'b0;
      w_wr_dirty  = 1'b0;
      w_clr_dirty = 1'b0;
      w_touch     = 1'b0;
      w_cnt_hit   = 1'b0;
      w_cnt_miss  = 1'b0;
      w_wr_idx    = w_ridx;
      w_wr_way    = r_way;
      w_wr_tag    = w_rtag;
      w_wr_data   = r_wdata;
      case (r_state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               w_accept  = 1'b1;
               w_wr_idx  = w_idx;
               w_wr_way  = w_acc_way;
               w_wr_tag  = w_tag;
               w_wr_data = req_wdata;
               if (w_hit) begin
                  w_cnt_hit  = 1'b1;
                  w_touch    = 1'b1;
                  w_wr_en    = req_write;
                  w_wr_dirty = 1'b1;
                  w_next     = S_RESP;
               end else begin
                  w_cnt_miss = 1'b1;
                  if (w_vict_dirty) begin
                     w_next = S_WRITEBACK;
                  end else if (!req_write) begin
                     w_next = S_REFILL;
                  end else begin
                     w_wr_en    = 1'b1;
                     w_wr_dirty = 1'b1;
                     w_touch    = 1'b1;
                     w_next     = S_RESP;
                  end
               end
            end
         end
         S_RESP: begin
            resp_valid = 1'b1;
            w_next     = S_IDLE;
         end
         S_WRITEBACK: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {r_tag[w_ridx][r_way], w_ridx};
            mem_wdata = r_data[w_ridx][r_way];
            if (mem_ack) begin
               if (r_write) begin
                  w_wr_en    = 1'b1;
                  w_wr_dirty = 1'b1;
                  w_touch    = 1'b1;
                  w_next     = S_RESP;
               end else begin
                  w_clr_dirty = 1'b1;
                  w_next      = S_REFILL;
               end
            end
         end
         S_REFILL: begin
            mem_req  = 1'b1;
            mem_addr = r_addr;
            if (mem_ack) begin
               w_wr_en   = 1'b1;
               w_wr_data = mem_rdata;
               w_touch   = 1'b1;
               w_next    = S_RESP;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Control state: valid/dirty/age and counters are the only reset registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            for (int k = 0; k < NUM_WAYS; k++) begin
               r_valid[s][k] <= 1'b0;
               r_dirty[s][k] <= 1'b0;
               r_age[s][k]   <= WAY_W'(k);
            end
         end
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else begin
         if (w_wr_en) begin
            r_valid[w_wr_idx][w_wr_way] <= 1'b1;
            r_dirty[w_wr_idx][w_wr_way] <= w_wr_dirty;
         end
         if (w_clr_dirty) r_dirty[w_ridx][r_way] <= 1'b0;
         if (w_touch) begin
            for (int k = 0; k < NUM_WAYS; k++) begin
               if (WAY_W'(k) == w_wr_way)
                  r_age[w_wr_idx][k] <= '0;
               else if (r_age[w_wr_idx][k] < r_age[w_wr_idx][w_wr_way])
                  r_age[w_wr_idx][k] <= r_age[w_wr_idx][k] + 1'b1;
            end
         end
         if (w_cnt_hit)  r_hit_cnt  <= sat_inc(r_hit_cnt);
         if (w_cnt_miss) r_miss_cnt <= sat_inc(r_miss_cnt);
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_tag[w_wr_idx][w_wr_way]  <= w_wr_tag;
         r_data[w_wr_idx][w_wr_way] <= w_wr_data;
      end
      if (w_accept) begin
         r_addr  <= req_addr;
         r_wdata <= req_wdata;
         r_write <= req_write;
         r_hit   <= w_hit;
         r_way   <= w_acc_way;
         r_rdata <= (w_hit && !req_write) ? r_data[w_idx][w_hit_way] : '0;
      end else if ((r_state == S_REFILL) && mem_ack) begin
         r_rdata <= mem_rdata;
      end
   end

   assign resp_hit   = (r_state == S_RESP) && r_hit;
   assign resp_rdata = (r_state == S_RESP) ? r_rdata : '0;
   assign hit_count  = r_hit_cnt;
   assign miss_count = r_miss_cnt;

endmodule
